// File: rtl/affine_addr_gen.sv
// affine_addr_gen: nested-loop strided address generator with a valid/ready output
module affine_addr_gen #(
  parameter int NUM_DIMS = 6,
  parameter int ADDR_W   = 16,
  parameter int RANGE_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               start,
  input  logic [3:0]         dimensionality,
  input  logic [ADDR_W-1:0]  starting_addr,
  input  logic [ADDR_W-1:0]  stride_0,
  input  logic [ADDR_W-1:0]  stride_1,
  input  logic [ADDR_W-1:0]  stride_2,
  input  logic [ADDR_W-1:0]  stride_3,
  input  logic [ADDR_W-1:0]  stride_4,
  input  logic [ADDR_W-1:0]  stride_5,
  input  logic [RANGE_W-1:0] range_0,
  input  logic [RANGE_W-1:0] range_1,
  input  logic [RANGE_W-1:0] range_2,
  input  logic [RANGE_W-1:0] range_3,
  input  logic [RANGE_W-1:0] range_4,
  input  logic [RANGE_W-1:0] range_5,
  input  logic [RANGE_W-1:0] iter_cnt,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               addr_valid,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [3:0]         dim_q, dim_in;
  logic [ADDR_W-1:0]  base_q, sum;
  logic [RANGE_W-1:0] iter_q, emitted_q;
  logic [ADDR_W-1:0]  stride_in [6];
  logic [RANGE_W-1:0] range_in [6];
  logic [ADDR_W-1:0]  stride_q [6];
  logic [RANGE_W-1:0] last_q [6];
  logic [RANGE_W-1:0] cnt_q [6], cnt_d [6];
  logic [ADDR_W-1:0]  off_q [6], off_d [6];
  logic               carry, at_max;
  assign stride_in = '{stride_0, stride_1, stride_2, stride_3, stride_4, stride_5};
  assign range_in  = '{range_0, range_1, range_2, range_3, range_4, range_5};
  assign dim_in = dimensionality == 4'd0 ? 4'd1 :
                  (dimensionality > 4'(NUM_DIMS) ? 4'(NUM_DIMS) : dimensionality);
  // Odometer step: a dimension moves only when every lower one sits at its last count.
  always_comb begin
    cnt_d = cnt_q;
    off_d = off_q;
    carry = 1'b1;
    at_max = 1'b0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      at_max = (i >= int'(dim_q)) || (cnt_q[i] == last_q[i]);
      if (carry) begin
        cnt_d[i] = at_max ? '0 : cnt_q[i] + 1'b1;
        off_d[i] = at_max ? '0 : off_q[i] + stride_q[i];
      end
      carry = carry & at_max;
    end
  end
  always_comb begin
    sum = base_q;
    for (int i = 0; i < NUM_DIMS; i++) sum = sum + off_q[i];
  end
  assign addr_out   = sum;
  assign addr_valid = state_q == RUN;
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dim_q     <= '0;
      base_q    <= '0;
      iter_q    <= '0;
      emitted_q <= '0;
      for (int i = 0; i < 6; i++) begin
        stride_q[i] <= '0;
        last_q[i]   <= '0;
        cnt_q[i]    <= '0;
        off_q[i]    <= '0;
      end
    end else if (flush) begin
      state_q   <= IDLE;
      emitted_q <= '0;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= '0;
        off_q[i] <= '0;
      end
    end else if (clk_en) begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= iter_cnt == '0 ? DONE : RUN;
          dim_q     <= dim_in;
          base_q    <= starting_addr;
          iter_q    <= iter_cnt;
          emitted_q <= '0;
          for (int i = 0; i < 6; i++) begin
            stride_q[i] <= stride_in[i];
            last_q[i]   <= range_in[i] == '0 ? '0 : range_in[i] - 1'b1;
            cnt_q[i]    <= '0;
            off_q[i]    <= '0;
          end
        end
        RUN: if (addr_ready) begin
          state_q   <= emitted_q == iter_q - 1'b1 ? DONE : RUN;
          emitted_q <= emitted_q + 1'b1;
          cnt_q     <= cnt_d;
          off_q     <= off_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_affine_addr_gen.sv
// tb_affine_addr_gen: randomized and directed checks against a mixed-radix address model
module tb_affine_addr_gen;
  logic        clk = 1'b0, reset, clk_en, flush, start, addr_ready;
  logic [3:0]  dimensionality;
  logic [15:0] starting_addr;
  logic [15:0] stride [6];
  logic [31:0] range_a [6];
  logic [31:0] iter_cnt;
  logic [15:0] addr_out;
  logic        addr_valid, busy, done;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  affine_addr_gen dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .start(start),
    .dimensionality(dimensionality), .starting_addr(starting_addr),
    .stride_0(stride[0]), .stride_1(stride[1]), .stride_2(stride[2]),
    .stride_3(stride[3]), .stride_4(stride[4]), .stride_5(stride[5]),
    .range_0(range_a[0]), .range_1(range_a[1]), .range_2(range_a[2]),
    .range_3(range_a[3]), .range_4(range_a[4]), .range_5(range_a[5]),
    .iter_cnt(iter_cnt), .addr_ready(addr_ready), .addr_out(addr_out),
    .addr_valid(addr_valid), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint eff_r(int i);
    return range_a[i] == 0 ? 1 : longint'(range_a[i]);
  endfunction
  // Address n is the mixed-radix decomposition of n modulo the full loop volume.
  function automatic logic [15:0] model_addr(int n);
    int d = dimensionality == 0 ? 1 : (dimensionality > 6 ? 6 : int'(dimensionality));
    longint prod = 1, k;
    logic [15:0] a = starting_addr;
    for (int i = 0; i < d; i++) prod *= eff_r(i);
    k = n % prod;
    for (int i = 0; i < d; i++) begin
      a += 16'((k % eff_r(i)) * longint'(stride[i]));
      k /= eff_r(i);
    end
    return a;
  endfunction
  task automatic set_raster();
    dimensionality = 4'd3;
    starting_addr = 16'd0;
    iter_cnt = 32'd27;
    stride = '{16'd1, 16'd3, 16'd9, 16'd0, 16'd0, 16'd0};
    range_a = '{32'd3, 32'd3, 32'd3, 32'd1, 32'd1, 32'd1};
  endtask
  task automatic set_wrap();
    dimensionality = 4'd1;
    starting_addr = 16'd100;
    iter_cnt = 32'd6;
    stride = '{16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    range_a = '{32'd4, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  // rmode: 0 always ready, 1 ready pattern 1,0,0, 2 random; gap_at: cycle where clk_en drops for 4 cycles
  task automatic run(input int rmode, input int gap_at, input string nm);
    int n = 0, cyc = 0, last_hs = -1, done_cyc = -1, busy_cnt = 0;
    logic pv = 1'b0, phs = 1'b0, hs;
    logic [15:0] pa = '0;
    pulse_start();
    while (done_cyc < 0 && cyc < 2000) begin
      addr_ready = rmode == 0 ? 1'b1 : (rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1)));
      clk_en = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 4);
      @(negedge clk);
      if (pv && !phs) begin
        chk({nm, " hold_addr"}, addr_out, pa);
        chk({nm, " hold_valid"}, addr_valid, 1);
      end
      chk({nm, " valid_eq_busy"}, addr_valid, busy);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        chk({nm, " valid_at_done"}, addr_valid, 0);
      end else if (n < int'(iter_cnt)) chk({nm, " valid"}, addr_valid, 1);
      hs = addr_valid && addr_ready && clk_en;
      if (hs) begin
        chk({nm, " addr"}, addr_out, model_addr(n));
        n++;
        last_hs = cyc;
      end
      pv = addr_valid;
      pa = addr_out;
      phs = hs;
      cyc++;
      @(posedge clk); #1;
    end
    addr_ready = 1'b1;
    clk_en = 1'b1;
    chk({nm, " count"}, n, iter_cnt);
    chk({nm, " done_at"}, done_cyc, last_hs + 1);
    chk({nm, " busy_cycles"}, busy_cnt, last_hs + 1);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic abort_run(input bit use_reset, input string nm);
    set_raster();
    addr_ready = 1'b1;
    pulse_start();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk({nm, " pre_addr"}, addr_out, model_addr(n));
      @(posedge clk); #1;
    end
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk({nm, " valid_after"}, addr_valid, 0);
    chk({nm, " busy_after"}, busy, 0);
    for (int c = 0; c < 3; c++) begin
      chk({nm, " no_done"}, done, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    run(0, -1, {nm, "_restart"});
  endtask
  initial begin
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; start = 1'b0; addr_ready = 1'b1;
    set_raster();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset addr_out", addr_out, 0);
    chk("reset addr_valid", addr_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    @(posedge clk); #1;
    set_raster();
    run(0, -1, "raster");
    set_wrap();
    run(0, -1, "wrap");
    run(1, -1, "backpressure");
    iter_cnt = 32'd0;
    run(0, -1, "zero_iter");
    abort_run(1'b0, "flush");
    abort_run(1'b1, "reset");
    set_wrap();
    dimensionality = 4'd0;
    range_a[0] = 32'd0;
    iter_cnt = 32'd3;
    run(0, 1, "clamp_en");
    set_raster();
    run(0, 6, "raster_en");
    for (int t = 0; t < 8; t++) begin
      dimensionality = 4'($urandom_range(0, 9));
      starting_addr = 16'($urandom);
      iter_cnt = 32'($urandom_range(0, 40));
      for (int i = 0; i < 6; i++) begin
        stride[i] = 16'($urandom);
        range_a[i] = 32'($urandom_range(0, 4));
      end
      run(2, int'($urandom_range(0, 12)), $sformatf("rand%0d", t));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/affine_addr_gen.md
Name: affine_addr_gen

Overview:
- Multi-dimensional strided address generator. It sits directly upstream of memory_core and drives that block's addr_in/ren_in pair.
- It walks up to six nested loop counters (range_i, stride_i) from starting_addr and emits one address per valid/ready handshake.
- It stops after iter_cnt addresses.
- It takes the same configuration fields that memory_core carries, so tile configs are reused unchanged.

Parameters:
- NUM_DIMS, 6, number of loop dimensions implemented.
- ADDR_W, 16, address and stride width.
- RANGE_W, 32, range and iteration-count width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  global enable; when low, all state is frozen.
- flush  in  1  synchronous abort to IDLE; configuration is kept.
- start  in  1  pulse; latches configuration and begins a sequence.
- dimensionality  in  4  number of active dimensions.
- starting_addr  in  ADDR_W  base address.
- stride_0..stride_5  in  ADDR_W each  per-dimension stride.
- range_0..range_5  in  RANGE_W each  per-dimension trip count.
- iter_cnt  in  RANGE_W  total addresses to emit.
- addr_ready  in  1  consumer accepts addr_out this cycle.
- addr_out  out  ADDR_W  current address.
- addr_valid  out  1  addr_out is valid.
- busy  out  1  a sequence is in progress (state RUN).
- done  out  1  one-cycle pulse at the end of a sequence.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE; every counter and offset register is 0; addr_valid=0, busy=0, done=0, addr_out=0.
- clk_en=0: no state, counter or output changes. A handshake is never counted while clk_en=0. reset and flush still take effect regardless of clk_en.
- flush=1: next state is IDLE; counters cleared; addr_valid=0; done not pulsed. Latched configuration registers are kept.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on start=1 with clk_en=1. On that edge the block latches dimensionality, starting_addr, strides, ranges and iter_cnt; all cnt_i=0, off_i=0, emitted=0.
  - IDLE with start=1 and iter_cnt=0: go directly to DONE; no address is emitted.
  - RUN to DONE on a handshake (addr_valid & addr_ready) when emitted==iter_cnt-1.
  - DONE to IDLE unconditionally after one cycle. done=1 only while in DONE.
  - start is ignored in RUN and DONE.
- Latency: addr_valid=1 in the first cycle after start is accepted. In RUN, addr_valid=1 continuously.
- addr_out = starting_addr + off_0 + ... + off_5, truncated to ADDR_W (modulo 2^16). It is driven combinationally from registers and has no extra pipeline stage.
- Dimension clamping:
  - Effective dimensionality D = clamp(dimensionality, 1, NUM_DIMS); 0 is treated as 1, values above 6 are treated as 6.
  - Dimensions i >= D keep cnt_i=0 and off_i=0.
  - Effective range R_i = max(range_i, 1).
- Advance, on each handshake in RUN:
  - Find the lowest i < D with cnt_i != R_i-1.
  - Set cnt_i += 1 and off_i += stride_i (mod 2^16).
  - Clear cnt_j and off_j to 0 for all j < i.
  - emitted += 1.
- Wrap: if every active dimension is at R_i-1, all counters and offsets clear to 0 and the sequence restarts at starting_addr. Emission continues until iter_cnt is reached.
- Backpressure: while addr_ready=0, addr_out and addr_valid hold stable. Valid never drops without a handshake, except on reset or flush.
- Reset or flush mid-sequence: the cycle after, addr_valid=0 and the block is in IDLE. The next start begins from starting_addr again.
- No combinational path from addr_ready to addr_valid.
- Implementation: offsets are updated incrementally; no multipliers are used.

Test Plan:
- 3-D raster: dimensionality=3, strides 1/3/9, ranges 3/3/3, strides 3-5=0, ranges 3-5=1, starting_addr=0, iter_cnt=27, addr_ready=1. Required: addr_out = 0,1,...,26 on 27 consecutive cycles; done pulses in the cycle after address 26; busy=1 for exactly 27 cycles.
- Wrap: D=1, starting_addr=100, stride_0=2, range_0=4, iter_cnt=6. Required: 100,102,104,106,100,102, then done.
- Backpressure: same as the wrap case with addr_ready toggling 1,0,0,1,... Required: the same address sequence; addr_out is stable while ready=0; the emitted count advances only on handshakes.
- Zero iterations: iter_cnt=0 with a start pulse. Required: addr_valid is never 1; done=1 two cycles after start; busy=0 throughout.
- Abort: flush, and separately reset, asserted after the 5th handshake of the raster case. Required: addr_valid=0 the next cycle and no done pulse. A restart then emits from address 0.
- Clamping and enable: dimensionality=0 with range_0=0 and iter_cnt=3. Required: addr_out=starting_addr for three handshakes. Holding clk_en low for 4 cycles mid-run freezes addr_out and the emitted count.
